// File: rtl/gb_instr_issuer.sv
// Instruction issue stage feeding gbprocessor: buffers opcode/operand pairs in a
// small FIFO and issues each as a one-cycle valid pulse, spaced by GAP idle cycles.
module gb_instr_issuer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             in_instruction,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [7:0]             instruction,
  output logic [7:0]             data_out,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            issued
);

  // state | meaning
  // IDLE  | nothing in flight; issue the FIFO head as soon as one exists
  // ISSUE | valid is high for this single cycle
  // WAIT  | enforced idle gap, gap_cnt counts down to 1

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] GAP_LD = 4'(GAP);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_next;
  logic [7:0]  mem_instr [DEPTH];
  logic [7:0]  mem_data  [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [3:0]  gap_cnt;
  logic        full, empty, push, pop, load_gap;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full && !reset && !flush;
  assign push     = in_valid && in_ready;
  assign count    = wr_ptr - rd_ptr;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_gap   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (GAP == 0) begin
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
        end else begin
          load_gap   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // last gap cycle issues directly, so exactly GAP low cycles sit between pulses
        if (gap_cnt <= 4'd1) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_instr[wr_ptr[AW-1:0]] <= in_instruction;
      mem_data[wr_ptr[AW-1:0]]  <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      gap_cnt     <= '0;
      valid       <= 1'b0;
      instruction <= '0;
      data_out    <= '0;
      issued      <= '0;
    end else if (flush) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      gap_cnt     <= '0;
      valid       <= 1'b0;
      instruction <= '0;
      data_out    <= '0;
    end else begin
      state <= state_next;
      valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        instruction <= mem_instr[rd_ptr[AW-1:0]];
        data_out    <= mem_data[rd_ptr[AW-1:0]];
        issued      <= issued + 16'd1;
      end
      if (load_gap)           gap_cnt <= GAP_LD;
      else if (state == WAIT) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_gb_instr_issuer.sv
// Bench for gb_instr_issuer: four parameterisations share one stimulus stream; a
// per-instance scoreboard tracks order, occupancy, spacing, ready and issued count.
module tb_gb_instr_issuer;
  localparam int NI = 4;
  localparam int DP [NI] = '{8, 4, 8, 8};
  localparam int GP [NI] = '{1, 0, 15, 2};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, flush, in_valid;
  logic [7:0] in_instruction, in_data;
  logic       ready_v  [NI];
  logic       valid_v  [NI];
  logic [7:0] instr_v  [NI];
  logic [7:0] data_v   [NI];
  logic [3:0] count_v  [NI];
  logic [15:0] issued_v [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(DP[g]):0] cnt;
    gb_instr_issuer #(.DEPTH(DP[g]), .GAP(GP[g])) dut (
      .clock(clock), .reset(reset),
      .in_instruction(in_instruction), .in_data(in_data),
      .in_valid(in_valid), .in_ready(ready_v[g]), .flush(flush),
      .instruction(instr_v[g]), .data_out(data_v[g]), .valid(valid_v[g]),
      .count(cnt), .issued(issued_v[g])
    );
    assign count_v[g] = 4'(cnt);
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk_eq(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_true(input string nm, input bit ok, input int act, input int expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, expv);
    end
  endtask

  task automatic drive(input bit rst, input bit fl, input bit iv,
                       input logic [7:0] ii, input logic [7:0] id);
    @(posedge clock);
    #1;
    reset = rst; flush = fl; in_valid = iv; in_instruction = ii; in_data = id;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] sbq [NI][64];
  int   qh [NI], qt [NI], mcount [NI], miss [NI], last_cyc [NI];
  int   last_i [NI], last_d [NI];
  bit   last_ok [NI], last_ne [NI], p_push [NI];
  bit   p_rst = 1'b1, p_fl = 1'b0, mon_on = 1'b0;
  logic [15:0] p_word;
  int   cyc = 0;

  always @(negedge clock) begin : mon
    logic [15:0] w;
    int   lowc;
    bit   pop, er;
    if (mon_on) begin
      for (int i = 0; i < NI; i++) begin
        if (p_rst || p_fl) begin
          qh[i] = 0; qt[i] = 0; mcount[i] = 0; last_ok[i] = 1'b0;
          last_i[i] = 0; last_d[i] = 0;
          if (p_rst) miss[i] = 0;
          chk_eq($sformatf("u%0d_clr_valid", i), int'(valid_v[i]), 0);
          chk_eq($sformatf("u%0d_clr_instr", i), int'(instr_v[i]), 0);
          chk_eq($sformatf("u%0d_clr_data", i), int'(data_v[i]), 0);
          chk_eq($sformatf("u%0d_clr_count", i), int'(count_v[i]), 0);
          chk_eq($sformatf("u%0d_clr_issued", i), int'(issued_v[i]), miss[i]);
        end else begin
          pop = valid_v[i];
          if (pop) begin
            if (qh[i] == qt[i]) begin
              chk_true($sformatf("u%0d_issue_from_empty", i), 1'b0, 1, 0);
            end else begin
              w = sbq[i][qh[i] % 64];
              qh[i]++;
              last_i[i] = int'(w[15:8]);
              last_d[i] = int'(w[7:0]);
              chk_eq($sformatf("u%0d_issue_instr", i), int'(instr_v[i]), last_i[i]);
              chk_eq($sformatf("u%0d_issue_data", i), int'(data_v[i]), last_d[i]);
            end
            miss[i] = (miss[i] + 1) & 16'hFFFF;
            if (last_ok[i]) begin
              lowc = cyc - last_cyc[i] - 1;
              if (last_ne[i]) chk_eq($sformatf("u%0d_gap_exact", i), lowc, GP[i]);
              else chk_true($sformatf("u%0d_gap_min", i), lowc >= GP[i], lowc, GP[i]);
            end
          end else begin
            chk_eq($sformatf("u%0d_hold_instr", i), int'(instr_v[i]), last_i[i]);
            chk_eq($sformatf("u%0d_hold_data", i), int'(data_v[i]), last_d[i]);
          end
          if (p_push[i]) begin
            sbq[i][qt[i] % 64] = p_word;
            qt[i]++;
          end
          mcount[i] = mcount[i] + int'(p_push[i]) - int'(pop);
          chk_eq($sformatf("u%0d_count", i), int'(count_v[i]), mcount[i]);
          chk_eq($sformatf("u%0d_issued", i), int'(issued_v[i]), miss[i]);
          if (pop) begin
            last_ok[i] = 1'b1; last_cyc[i] = cyc; last_ne[i] = (mcount[i] > 0);
          end
        end
        er = (mcount[i] < DP[i]) && !reset && !flush;
        chk_eq($sformatf("u%0d_in_ready", i), int'(ready_v[i]), int'(er));
        p_push[i] = in_valid && er;
      end
      p_rst = reset; p_fl = flush; p_word = {in_instruction, in_data};
      cyc++;
    end
  end

  // ---------------- directed table for instance 0 (DEPTH 8, GAP 1) ----------------
  typedef struct {
    bit rst, fl, iv;
    logic [7:0] ii, id;
    int e_valid, e_instr, e_data, e_count, e_ready, e_issued;
  } vec_t;
  vec_t tbl [15];

  task automatic drain_all(input string nm);
    bit done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      done = 1'b1;
      for (int i = 0; i < NI; i++) if (count_v[i] != 0 || valid_v[i]) done = 1'b0;
    end
    chk_eq(nm, int'(done), 1);
    repeat (20) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bit hit;
    int base [NI];
    int base_c;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 0, 'h00, 'h00, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 'h00, 'h00, 0, 1, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h80, 8'h05, 0, 'h00, 'h00, 0, 1, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 'h00, 'h00, 1, 1, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1, 'h80, 'h05, 0, 1, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 'h80, 'h05, 0, 1, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h31, 8'h41, 0, 'h80, 'h05, 0, 1, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h32, 8'h42, 0, 'h80, 'h05, 1, 1, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1, 'h31, 'h41, 1, 1, 2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 'h31, 'h41, 1, 1, 2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1, 'h32, 'h42, 0, 1, 3};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h55, 8'h66, 0, 'h32, 'h42, 0, 1, 3};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h77, 8'h88, 0, 'h32, 'h42, 1, 0, 3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 'h00, 'h00, 0, 1, 3};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 'h00, 'h00, 0, 1, 3};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_instruction = 8'hAA; in_data = 8'hBB;
    @(posedge clock);
    #1 mon_on = 1'b1;

    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].rst, tbl[r].fl, tbl[r].iv, tbl[r].ii, tbl[r].id);
      @(negedge clock);
      chk_eq($sformatf("tbl%0d_valid", r), int'(valid_v[0]), tbl[r].e_valid);
      chk_eq($sformatf("tbl%0d_instr", r), int'(instr_v[0]), tbl[r].e_instr);
      chk_eq($sformatf("tbl%0d_data", r), int'(data_v[0]), tbl[r].e_data);
      chk_eq($sformatf("tbl%0d_count", r), int'(count_v[0]), tbl[r].e_count);
      chk_eq($sformatf("tbl%0d_ready", r), int'(ready_v[0]), tbl[r].e_ready);
      chk_eq($sformatf("tbl%0d_issued", r), int'(issued_v[0]), tbl[r].e_issued);
    end

    // continuous producer: instance 2 (GAP 15) fills up, others stream through
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 8'(8'hC0 + k));
      @(negedge clock);
      if (k == 12) begin
        chk_eq("full_count_u2", int'(count_v[2]), 8);
        chk_eq("full_ready_u2", int'(ready_v[2]), 0);
      end
    end

    // let instance 2 drain to 3 entries, then flush mid-WAIT with a push pending
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      if (count_v[2] == 3) hit = 1'b1;
    end
    chk_eq("reach_count3_u2", int'(hit), 1);
    repeat (2) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
    end
    chk_eq("prefl_count_u2", int'(count_v[2]), 3);
    chk_eq("prefl_valid_u2", int'(valid_v[2]), 0);
    base_c = miss[2];
    drive(1'b0, 1'b1, 1'b1, 8'hEE, 8'hEF);
    @(negedge clock);
    chk_eq("fl_ready_u2", int'(ready_v[2]), 0);
    drive(1'b0, 1'b0, 1'b1, 8'h9A, 8'h9B);
    @(negedge clock);
    chk_eq("postfl_count_u2", int'(count_v[2]), 0);
    chk_eq("postfl_valid_u2", int'(valid_v[2]), 0);
    chk_eq("postfl_instr_u2", int'(instr_v[2]), 0);
    chk_eq("postfl_issued_u2", int'(issued_v[2]), base_c);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    chk_eq("lat_count_u2", int'(count_v[2]), 1);
    chk_eq("lat_novalid_u2", int'(valid_v[2]), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    chk_eq("lat_valid_u2", int'(valid_v[2]), 1);
    chk_eq("lat_instr_u2", int'(instr_v[2]), 'h9A);
    chk_eq("lat_data_u2", int'(data_v[2]), 'h9B);
    chk_eq("lat_issued_u2", int'(issued_v[2]), base_c + 1);
    drain_all("drain_after_flush");

    // burst of five back-to-back pushes
    for (int i = 0; i < NI; i++) base[i] = miss[i];
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 8'(8'hA0 + k), 8'(8'h50 + k));
      @(negedge clock);
    end
    drain_all("drain_after_burst");
    for (int i = 0; i < NI; i++)
      chk_eq($sformatf("burst_issued_u%0d", i), int'(issued_v[i]), base[i] + 5);

    // reset while gaps are in progress: no leftover pulse afterwards
    drive(1'b0, 1'b0, 1'b1, 8'hD1, 8'hE1);
    drive(1'b0, 1'b0, 1'b1, 8'hD2, 8'hE2);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      chk_eq($sformatf("rst_valid_u%0d", i), int'(valid_v[i]), 0);
      chk_eq($sformatf("rst_issued_u%0d", i), int'(issued_v[i]), 0);
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      chk_eq("rst_no_pulse_u2", int'(valid_v[2]), 0);
    end
    for (int i = 0; i < NI; i++)
      chk_eq($sformatf("end_count_u%0d", i), int'(count_v[i]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
